// File: rtl/fp_mul_pipe_if.sv
// Streaming handshake bundle for the pipelined floating-point multiplier.
// The producer/consumer side uses the master modport and the multiplier uses slave.
interface fp_mul_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = EXP_W + MAN_W + 1;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [3:0]   flags;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined floating-point multiplier with generic exponent and
// fraction widths, round-to-nearest-even, flush-to-zero on subnormal inputs,
// no subnormal outputs, and {invalid, overflow, underflow, inexact} flags.
module fp_mul_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic         clk,
  input  logic         rst,
  fp_mul_pipe_if.slave bus
);
  localparam int W  = EXP_W + MAN_W + 1;
  localparam int PW = 2 * MAN_W + 2;
  localparam int EW = EXP_W + 2;
  localparam logic signed [EW-1:0] BIAS    = EW'(2 ** (EXP_W - 1) - 1);
  localparam logic signed [EW-1:0] EXP_TOP = EW'(2 ** EXP_W - 1);
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W - 1){1'b0}}};

  // Normalise the raw significand product and round to nearest even.
  // Returns {exponent increment (0..2), inexact, rounded fraction}.
  function automatic logic [MAN_W+2:0] norm_round(input logic [PW-1:0] p);
    logic             msb, guard, sticky, up;
    logic [MAN_W-1:0] frac;
    logic [MAN_W:0]   frac_r;
    msb = p[PW-1];
    if (msb) begin
      frac   = p[PW-2:MAN_W+1];
      guard  = p[MAN_W];
      sticky = |p[MAN_W-1:0];
    end else begin
      frac   = p[PW-3:MAN_W];
      guard  = p[MAN_W-1];
      sticky = |p[MAN_W-2:0];
    end
    up     = guard & (sticky | frac[0]);
    frac_r = {1'b0, frac} + (MAN_W + 1)'(up);
    // A carry out of the fraction leaves frac_r[MAN_W-1:0] at zero already.
    return {({1'b0, msb} + {1'b0, frac_r[MAN_W]}), (guard | sticky), frac_r[MAN_W-1:0]};
  endfunction

  // Saturate the final exponent to inf / signed zero, else pack normally.
  // Returns {flags, result}.
  function automatic logic [W+3:0] sat_pack(input logic s,
                                            input logic signed [EW-1:0] e,
                                            input logic [MAN_W-1:0] f,
                                            input logic inexact);
    if (e >= EXP_TOP)
      return {4'b0101, s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (e[EW-1] || (e == '0))
      return {4'b0011, s, {(W - 1){1'b0}}};
    else
      return {3'b000, inexact, s, e[EXP_W-1:0], f};
  endfunction

  logic advance, in_ready;
  assign advance      = bus.out_ready | ~bus.out_valid;
  assign in_ready     = advance & ~rst;
  assign bus.in_ready = in_ready;

  // ---- S1: unpack / classify ----
  logic [EXP_W-1:0] a_exp, b_exp;
  logic [MAN_W-1:0] a_frac, b_frac;
  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sign_d;
  logic             spec_d;
  logic [W-1:0]     sres_d;
  logic [3:0]       sflg_d;
  logic signed [EW-1:0] esum_d;

  assign a_exp  = bus.a[W-2:MAN_W];
  assign b_exp  = bus.b[W-2:MAN_W];
  assign a_frac = bus.a[MAN_W-1:0];
  assign b_frac = bus.b[MAN_W-1:0];
  assign a_zero = (a_exp == '0);
  assign b_zero = (b_exp == '0);
  assign a_inf  = (&a_exp) & (a_frac == '0);
  assign b_inf  = (&b_exp) & (b_frac == '0);
  assign a_nan  = (&a_exp) & (|a_frac);
  assign b_nan  = (&b_exp) & (|b_frac);
  assign sign_d = bus.a[W-1] ^ bus.b[W-1];
  assign esum_d = $signed({2'b00, a_exp}) + $signed({2'b00, b_exp}) - BIAS;

  // Resolve special operands up front; they bypass the arithmetic flags.
  always_comb begin
    spec_d = 1'b1;
    sres_d = '0;
    sflg_d = 4'b0000;
    if (a_nan | b_nan) begin
      sres_d = QNAN;
    end else if ((a_zero & b_inf) | (a_inf & b_zero)) begin
      sres_d = QNAN;
      sflg_d = 4'b1000;
    end else if (a_inf | b_inf) begin
      sres_d = {sign_d, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (a_zero | b_zero) begin
      sres_d = {sign_d, {(W - 1){1'b0}}};
    end else begin
      spec_d = 1'b0;
    end
  end

  logic                 vld_p0_q, vld_p1_q, vld_p2_q;
  logic                 sign_p0_q, spec_p0_q;
  logic [W-1:0]         sres_p0_q;
  logic [3:0]           sflg_p0_q;
  logic signed [EW-1:0] esum_p0_q;
  logic [MAN_W:0]       ma_p0_q, mb_p0_q;

  // Stage valid bits shift together on advance; reset discards everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0_q <= 1'b0;
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
    end else if (advance) begin
      vld_p0_q <= bus.in_valid & in_ready;
      vld_p1_q <= vld_p0_q;
      vld_p2_q <= vld_p1_q;
    end
  end

  // Capture classified operands with the hidden one restored.
  always_ff @(posedge clk) begin
    if (advance) begin
      sign_p0_q <= sign_d;
      spec_p0_q <= spec_d;
      sres_p0_q <= sres_d;
      sflg_p0_q <= sflg_d;
      esum_p0_q <= esum_d;
      ma_p0_q   <= {1'b1, a_frac};
      mb_p0_q   <= {1'b1, b_frac};
    end
  end

  // ---- S2: full significand product ----
  logic [PW-1:0]        prod_d;
  logic                 sign_p1_q, spec_p1_q;
  logic [W-1:0]         sres_p1_q;
  logic [3:0]           sflg_p1_q;
  logic signed [EW-1:0] esum_p1_q;
  logic [PW-1:0]        prod_p1_q;

  assign prod_d = ma_p0_q * mb_p0_q;

  // Register the product alongside the carried sign/exponent/special info.
  always_ff @(posedge clk) begin
    if (advance) begin
      sign_p1_q <= sign_p0_q;
      spec_p1_q <= spec_p0_q;
      sres_p1_q <= sres_p0_q;
      sflg_p1_q <= sflg_p0_q;
      esum_p1_q <= esum_p0_q;
      prod_p1_q <= prod_d;
    end
  end

  // ---- S3: normalise / round / pack ----
  logic [MAN_W+2:0]     nr;
  logic signed [EW-1:0] e_fin;
  logic [W+3:0]         packed_w;
  logic [W-1:0]         result_d;
  logic [3:0]           flags_d;

  // Pick the special-case result when one was flagged in S1.
  always_comb begin
    nr       = norm_round(prod_p1_q);
    e_fin    = esum_p1_q + $signed({{(EW - 2){1'b0}}, nr[MAN_W+2:MAN_W+1]});
    packed_w = sat_pack(sign_p1_q, e_fin, nr[MAN_W-1:0], nr[MAN_W]);
    result_d = packed_w[W-1:0];
    flags_d  = packed_w[W+3:W];
    if (spec_p1_q) begin
      result_d = sres_p1_q;
      flags_d  = sflg_p1_q;
    end
  end

  logic [W-1:0] result_q;
  logic [3:0]   flags_q;

  // Output register only loads real results so it holds steady through bubbles and stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      flags_q  <= '0;
    end else if (advance & vld_p1_q) begin
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign bus.out_valid = vld_p2_q;
  assign bus.result    = result_q;
  assign bus.flags     = flags_q;
endmodule

// File: tb/tb_fp_mul_pipe.sv
// Directed scoreboard bench for fp_mul_pipe (single precision).
module tb_fp_mul_pipe;
  logic clk = 1'b0;
  logic rst;

  fp_mul_pipe_if #(.EXP_W(8), .MAN_W(23)) bus ();

  fp_mul_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [3:0]  f;
  } vec_t;

  localparam int NV = 15;
  vec_t vt [0:NV-1] = '{
    '{32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000}, // 1.5*2
    '{32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001}, // inexact, round down
    '{32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 4'b0101}, // overflow
    '{32'h00000000, 32'h7F800000, 32'h7FC00000, 4'b1000}, // 0*inf
    '{32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000}, // -inf*2
    '{32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011}, // underflow
    '{32'h80000000, 32'h3F800000, 32'h80000000, 4'b0000}, // -0*1
    '{32'h3FC00001, 32'h3FC00001, 32'h40100002, 4'b0001}, // round up
    '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b0000}, // NaN operand
    '{32'h7F800001, 32'h00000000, 32'h7FC00000, 4'b0000}, // NaN beats 0*x
    '{32'h00800000, 32'h3F800000, 32'h00800000, 4'b0000}, // min normal kept
    '{32'hFF7FFFFF, 32'h40000000, 32'hFF800000, 4'b0101}, // negative overflow
    '{32'h00000001, 32'hC0000000, 32'h80000000, 4'b0000}, // subnormal flushed
    '{32'h7F800000, 32'hC0000000, 32'hFF800000, 4'b0000}, // inf*-2
    '{32'h80800000, 32'h3F000000, 32'h80000000, 4'b0011}  // negative underflow
  };

  logic [35:0] exp_q [$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // Called at negedge+1; returns at the following negedge+1 with in_valid low.
  task automatic send(input vec_t v, input bit push);
    int w;
    w = 0;
    bus.a        = v.a;
    bus.b        = v.b;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && w < 100) begin
      @(negedge clk); #1;
      w++;
    end
    if (!bus.in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready stuck low for a=%h", v.a);
    end else if (push) begin
      exp_q.push_back({v.r, v.f});
    end
    @(negedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: pop and compare on every transfer, and check output stability under stall.
  logic        have_hold = 1'b0;
  logic [31:0] hold_res;
  logic [3:0]  hold_flg;
  always @(negedge clk) begin
    logic [35:0] e;
    #2;
    if (rst) begin
      have_hold = 1'b0;
    end else begin
      if (have_hold) begin
        check("hold_valid", 32'(bus.out_valid), 32'd1);
        check("hold_result", bus.result, hold_res);
        check("hold_flags", 32'(bus.flags), 32'(hold_flg));
        have_hold = 1'b0;
      end
      if (bus.out_valid) begin
        if (bus.out_ready) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_output: result %h flags %b with nothing outstanding",
                     bus.result, bus.flags);
          end else begin
            e = exp_q.pop_front();
            check("result", bus.result, e[35:4]);
            check("flags", 32'(bus.flags), 32'(e[3:0]));
          end
        end else begin
          hold_res  = bus.result;
          hold_flg  = bus.flags;
          have_hold = 1'b1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_result", bus.result, 32'd0);
    check("rst_flags", 32'(bus.flags), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("idle_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk); #1;

    // Latency of a lone operation
    send(vt[0], 1'b1);
    lat = 1;
    while (!bus.out_valid && lat < 10) begin
      @(negedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), 32'd3);
    drain();
    @(negedge clk); #1;

    // Directed table, back-to-back
    for (int i = 1; i < NV; i++) send(vt[i], 1'b1);
    drain();
    @(negedge clk); #1;

    // Four ops streamed while the consumer stalls for 5 cycles
    fork
      begin
        send(vt[1], 1'b1);
        send('{32'h40400000, 32'h40400000, 32'h41100000, 4'b0000}, 1'b1);
        send('{32'hC0000000, 32'h3F800000, 32'hC0000000, 4'b0000}, 1'b1);
        send(vt[7], 1'b1);
      end
      begin
        for (int i = 0; i < 30 && !bus.out_valid; i++) @(negedge clk);
        bus.out_ready = 1'b0;
        #3;
        check("stall_in_ready", 32'(bus.in_ready), 32'd0);
        repeat (5) @(negedge clk);
        bus.out_ready = 1'b1;
      end
    join
    drain();
    repeat (3) @(negedge clk);
    #1;

    // Reset with two operations in flight
    send(vt[2], 1'b0);
    send(vt[3], 1'b0);
    rst = 1'b1;
    exp_q.delete();
    bus.a        = vt[4].a;
    bus.b        = vt[4].b;
    bus.in_valid = 1'b1;
    #1;
    check("reset_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk); #1;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    check("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("post_rst_flags", 32'(bus.flags), 32'd0);
    check("post_rst_result", bus.result, 32'd0);
    repeat (8) @(negedge clk);
    #1;

    // Recovery after reset
    send(vt[7], 1'b1);
    drain();
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
